// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states,
// ALUop codes consumed by the ALU control decoder, mux selects and the control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       retire;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// Combinational decode of FSM state (plus mem_ready qualification) into the
// datapath control word.
module multicycle_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM_SL;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.retire     = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        ctrl.retire    = mem_ready;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.retire        = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.retire    = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle MIPS main control FSM: state register, next-state logic and
// reset-gated control outputs.
module multicycle_main_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       retire,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q, state_d;
  ctrl_t  ctrl;
  ctrl_t  ctrl_gated;
  logic   illegal_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
        illegal_d = !is_legal_op(opcode);
      end
      S_MEM_ADDR: begin
        if (opcode == OP_LW)      state_d = S_MEM_READ;
        else if (opcode == OP_SW) state_d = S_MEM_WRITE;
        else                      state_d = S_FETCH;
      end
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTE:   state_d = S_R_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  multicycle_ctrl_outdec u_outdec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Reset holds FETCH, whose decode would otherwise raise mem_read; gate everything.
  always_comb begin
    ctrl_gated = rst_n ? ctrl : '0;
  end

  assign pc_write      = ctrl_gated.pc_write;
  assign pc_write_cond = ctrl_gated.pc_write_cond;
  assign i_or_d        = ctrl_gated.i_or_d;
  assign mem_read      = ctrl_gated.mem_read;
  assign mem_write     = ctrl_gated.mem_write;
  assign ir_write      = ctrl_gated.ir_write;
  assign mem_to_reg    = ctrl_gated.mem_to_reg;
  assign reg_dst       = ctrl_gated.reg_dst;
  assign reg_write     = ctrl_gated.reg_write;
  assign alu_src_a     = ctrl_gated.alu_src_a;
  assign alu_src_b     = ctrl_gated.alu_src_b;
  assign alu_op        = ctrl_gated.alu_op;
  assign pc_source     = ctrl_gated.pc_source;
  assign retire        = ctrl_gated.retire;
  assign illegal_op    = rst_n & illegal_d;
  assign state         = state_q;

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multicycle MIPS datapath; the producer of the 2-bit ALUop that the ALU control decoder consumes.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives all datapath strobes and multiplexer selects, and waits on a memory-ready handshake.
- Supports R-type, lw, sw, beq and j; every other opcode is flagged as illegal.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_J, 6'b000010, jump opcode

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instruction register bits [31:26], valid from DECODE onward
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  register write data select: 0 = ALUOut, 1 = MDR
- reg_dst  out  1  destination register select: 0 = rt, 1 = rd
- reg_write  out  1  register file write
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
- alu_op  out  2  00 = add, 01 = subtract, 10 = use funct field
- pc_source  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
- retire  out  1  one-cycle pulse when an instruction completes
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9.
- Reset: asynchronous, with rst_n low.
  - state becomes FETCH immediately.
  - While rst_n is low, all outputs except state are forced to 0.
  - Reset in any state, including mid memory wait, returns to FETCH with no strobe emitted.
- Outputs are Moore, decoded from state. The only exception is the mem_ready qualification listed below. Any output not listed for a state is 0.
- FETCH:
  - Always: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=1 and pc_write=1 only in the cycle mem_ready=1.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00.
  - Next state by opcode: lw/sw -> MEM_ADDR, R-type -> EXECUTE, beq -> BRANCH, j -> JUMP.
  - Any other opcode: illegal_op=1 for this cycle, next state FETCH, no retire.
- MEM_ADDR:
  - alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next state: lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ:
  - mem_read=1, i_or_d=1.
  - Stay while mem_ready=0; go to MEM_WB when mem_ready=1.
- MEM_WB:
  - reg_write=1, mem_to_reg=1, reg_dst=0, retire=1.
  - Next state FETCH.
- MEM_WRITE:
  - mem_write=1, i_or_d=1. Both stay held through the wait.
  - retire=1 only in the cycle mem_ready=1.
  - Next state FETCH when mem_ready=1.
- EXECUTE:
  - alu_src_a=1, alu_src_b=00, alu_op=10.
  - Next state R_WB.
- R_WB:
  - reg_write=1, reg_dst=1, mem_to_reg=0, retire=1.
  - Next state FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, retire=1.
  - Next state FETCH.
- JUMP:
  - pc_write=1, pc_source=10, retire=1.
  - Next state FETCH.
- Cycle counts with mem_ready held at 1: lw 5, sw 4, R-type 4, beq 3, j 3.
- Each cycle mem_ready is low in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- opcode is sampled every cycle in DECODE and MEM_ADDR; the datapath holds the IR stable after the ir_write cycle.
- Unused state codes 10-15 decode all outputs to 0 and transition to FETCH.
- mem_read and mem_write are never asserted together.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants;
  - state encoding;
  - ALUop encodings (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10), shared with the ALU control decoder;
  - alu_src_b and pc_source select encodings.
- One sub-module: multicycle_ctrl_outdec, a combinational state-plus-mem_ready to control-word decoder.
- The top level keeps the state register and next-state logic.

Test Plan:
- lw (opcode 100011), mem_ready=1 -> states 0,1,2,3,4; alu_op 00 in MEM_ADDR; reg_write=1, mem_to_reg=1 in state 4; retire in cycle 5; back to FETCH.
- R-type (000000), mem_ready=1 -> states 0,1,6,7; alu_op=10 in EXECUTE; reg_write=1, reg_dst=1 in R_WB; retire on cycle 4.
- beq (000100) then j (000010) -> beq: 3 cycles, alu_op=01, pc_write_cond=1, pc_source=01; j: 3 cycles, pc_write=1, pc_source=10.
- sw (101011) with mem_ready low 3 cycles in FETCH and 2 cycles in MEM_WRITE -> FETCH lasts 4 cycles with ir_write asserted only in the 4th; mem_write held 3 cycles; retire only in the ready cycle.
- Illegal opcode 001000 -> illegal_op=1 for one cycle in DECODE, no retire, next state FETCH.
- rst_n dropped asynchronously mid-cycle in MEM_READ -> state=0 and all strobes 0 immediately; after release, a fresh FETCH with mem_read=1.
